truth_table_sequencer: RTL and testbench

Sequential stimulus-and-capture stage that wraps a small combinational function block, such as a 3-input single-output logic function. Upstream side: drives every input combination in ascending binary order and holds each vector for a programmable number of cycles. Downstream side: samples the function output at the end of each hold window into a truth-table register. Reports completion and the count of true minterms, so lab logic functions are exercised exhaustively in hardware rather than by hand-written delays.

---
 rtl/truth_table_sequencer_pkg.sv | 26 ++
 rtl/truth_table_sequencer_hold_timer.sv | 33 +++
 rtl/truth_table_sequencer.sv | 135 +++++++++++++
 tb/tb_truth_table_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_sequencer_pkg.sv
// Shared definitions for the truth-table sequencer: FSM state encoding,
// default geometry (input count, hold length, counter width) and a helper
// that derives the number of vectors in a sweep from the input count.
package truth_table_sequencer_pkg;

  // FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Default geometry
  localparam int N_IN_DEFAULT  = 3;
  localparam int HOLD_DEFAULT  = 10;
  localparam int CNT_W_DEFAULT = 8;

  // Number of vectors in one sweep for the default input count
  localparam int NUM_VEC = 2 ** N_IN_DEFAULT;

  // Number of vectors in one sweep for an arbitrary input count
  function automatic int num_vec(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/truth_table_sequencer_hold_timer.sv
// Hold-window timer: counts clock cycles within one vector's hold window.
// Ports: clk/rst (async active-high), load (clear to 0, wins over en),
//        en (count up), tc (terminal count, high when count == HOLD-1).
module hold_timer #(
  parameter int CNT_W = 8,
  parameter int HOLD  = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(HOLD - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // With HOLD == 1 the count sits at 0 and tc is permanently high, so every
  // DRIVE cycle is a capture cycle.
  assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/truth_table_sequencer.sv
// Truth-table sequencer: sweeps every input vector of a small combinational
// function in ascending order, holds each for HOLD cycles, and captures the
// function output at the end of each hold window into a truth-table register.
// Ports:
//   clk, rst       clock and asynchronous active-high reset
//   start          begin a sweep (only honoured in IDLE)
//   f_in           output of the function under test, driven from x_out
//   x_out          current input vector, MSB is the first function input
//   busy           high while vectors are being driven
//   done           single-cycle pulse after the last vector is captured
//   truth          captured table, bit k = f_in seen while x_out == k
//   ones_count     number of set bits in truth, held after the sweep
module truth_table_sequencer
  import truth_table_sequencer_pkg::*;
#(
  parameter int N_IN  = N_IN_DEFAULT,
  parameter int HOLD  = HOLD_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    f_in,
  output logic [N_IN-1:0]         x_out,
  output logic                    busy,
  output logic                    done,
  output logic [2**N_IN-1:0]      truth,
  output logic [N_IN:0]           ones_count
);

  localparam int              NV     = num_vec(N_IN);
  localparam logic [N_IN-1:0] X_LAST = '1;

  state_t            state, state_nxt;
  logic [N_IN-1:0]   x_nxt;
  logic              busy_nxt;
  logic              done_nxt;
  logic [NV-1:0]     truth_nxt;
  logic [N_IN:0]     ones_nxt;

  logic              tmr_load;
  logic              tmr_en;
  logic              tc;

  hold_timer #(
    .CNT_W (CNT_W),
    .HOLD  (HOLD)
  ) u_hold_timer (
    .clk  (clk),
    .rst  (rst),
    .load (tmr_load),
    .en   (tmr_en),
    .tc   (tc)
  );

  // State and all outputs are registered together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      x_out      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      truth      <= '0;
      ones_count <= '0;
    end else begin
      state      <= state_nxt;
      x_out      <= x_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      truth      <= truth_nxt;
      ones_count <= ones_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    x_nxt     = x_out;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    truth_nxt = truth;
    ones_nxt  = ones_count;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;

    case (state)
      ST_IDLE: begin
        // Keep the timer parked at 0 so the first window is a full HOLD.
        tmr_load = 1'b1;
        busy_nxt = 1'b0;
        if (start) begin
          state_nxt = ST_DRIVE;
          x_nxt     = '0;
          truth_nxt = '0;
          ones_nxt  = '0;
          busy_nxt  = 1'b1;
        end
      end

      ST_DRIVE: begin
        if (!tc) begin
          tmr_en = 1'b1;
        end else begin
          // End of the hold window: f_in has had HOLD cycles to settle.
          truth_nxt[x_out] = f_in;
          ones_nxt         = ones_count + (N_IN + 1)'(f_in);
          tmr_load         = 1'b1;
          if (x_out == X_LAST) begin
            // Last vector: stop here rather than wrapping back to 0.
            state_nxt = ST_DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            x_nxt = x_out + N_IN'(1);
          end
        end
      end

      ST_DONE: begin
        // start is deliberately not looked at here.
        state_nxt = ST_IDLE;
        x_nxt     = '0;
        busy_nxt  = 1'b0;
        tmr_load  = 1'b1;
      end

      default: begin
        state_nxt = ST_IDLE;
        x_nxt     = '0;
        busy_nxt  = 1'b0;
        tmr_load  = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Testbench for truth_table_sequencer: two instances (HOLD=10 and HOLD=1)
// driven with random function tables and random start noise, compared each
// cycle against a timing/table model derived from the sweep rules.
module tb_truth_table_sequencer;
  import truth_table_sequencer_pkg::*;

  localparam int NI = N_IN_DEFAULT;
  localparam int NV = NUM_VEC;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start0 = 1'b0, start1 = 1'b0;
  logic [NV-1:0] tbl0 = '0, tbl1 = '0;
  logic          f0, f1;

  logic [NI-1:0] x0, x1;
  logic          busy0, busy1, done0, done1;
  logic [NV-1:0] truth0, truth1;
  logic [NI:0]   ones0, ones1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Function under test: a lookup table indexed by the current vector.
  assign f0 = tbl0[x0];
  assign f1 = tbl1[x1];

  truth_table_sequencer #(.N_IN(NI), .HOLD(10), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .f_in(f0), .x_out(x0),
    .busy(busy0), .done(done0), .truth(truth0), .ones_count(ones0)
  );

  truth_table_sequencer #(.N_IN(NI), .HOLD(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .f_in(f1), .x_out(x1),
    .busy(busy1), .done(done1), .truth(truth1), .ones_count(ones1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // f = (x1 & x2) | ~x3, with x1 the MSB of the vector.
  function automatic logic [NV-1:0] spec_table();
    logic [NV-1:0] r;
    r = '0;
    for (int k = 0; k < NV; k++) begin
      r[k] = (((k >> 2) & 1) & ((k >> 1) & 1)) | (((k & 1) == 0) ? 1 : 0);
    end
    return r;
  endfunction

  // Table as seen after the first c vectors have been captured.
  function automatic logic [NV-1:0] partial(input logic [NV-1:0] tbl, input int c);
    logic [NV-1:0] r;
    r = '0;
    for (int k = 0; k < c; k++) r[k] = tbl[k];
    return r;
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) start0 = v; else start1 = v;
  endtask

  task automatic set_tbl(input int sel, input logic [NV-1:0] t);
    if (sel == 0) tbl0 = t; else tbl1 = t;
  endtask

  task automatic sample(input int sel, output logic [NI-1:0] x, output logic b,
                        output logic d, output logic [NV-1:0] tr, output logic [NI:0] on);
    if (sel == 0) begin
      x = x0; b = busy0; d = done0; tr = truth0; on = ones0;
    end else begin
      x = x1; b = busy1; d = done1; tr = truth1; on = ones1;
    end
  endtask

  // One full sweep. t counts negedges after the start edge E0.
  task automatic sweep(input int sel, input logic [NV-1:0] tbl, input bit noise);
    int h, c, busy_n, done_n, ex;
    logic [NI-1:0] x;
    logic b, d;
    logic [NV-1:0] tr, et;
    logic [NI:0] on;
    h = (sel == 0) ? 10 : 1;
    busy_n = 0;
    done_n = 0;
    set_tbl(sel, tbl);
    @(negedge clk);
    set_start(sel, 1'b1);
    @(negedge clk);
    for (int t = 0; t <= NV * h + 1; t++) begin
      sample(sel, x, b, d, tr, on);
      c = t / h;
      if (c > NV) c = NV;
      et = partial(tbl, c);
      if (t < NV * h) ex = t / h;
      else if (t == NV * h) ex = NV - 1;
      else ex = 0;
      check($sformatf("s%0d t%0d x_out", sel, t), 32'(x), 32'(ex));
      check($sformatf("s%0d t%0d busy", sel, t), 32'(b), (t < NV * h) ? 1 : 0);
      check($sformatf("s%0d t%0d done", sel, t), 32'(d), (t == NV * h) ? 1 : 0);
      check($sformatf("s%0d t%0d truth", sel, t), 32'(tr), 32'(et));
      check($sformatf("s%0d t%0d ones", sel, t), 32'(on), $countones(et));
      busy_n += int'(b);
      done_n += int'(d);
      // start noise lands only on DRIVE/DONE edges; IDLE afterwards gets 0.
      if (noise && t < NV * h + 1) set_start(sel, 1'($urandom_range(0, 1)));
      else set_start(sel, 1'b0);
      @(negedge clk);
    end
    check($sformatf("s%0d busy_cycles", sel), busy_n, NV * h);
    check($sformatf("s%0d done_pulses", sel), done_n, 1);
  endtask

  logic [NV-1:0] rt;

  initial begin
    // Reset state
    #1 rst = 1'b1;
    #1;
    check("rst x0", 32'(x0), 0);
    check("rst busy0", 32'(busy0), 0);
    check("rst done0", 32'(done0), 0);
    check("rst truth0", 32'(truth0), 0);
    check("rst ones0", 32'(ones0), 0);
    check("rst truth1", 32'(truth1), 0);
    @(negedge clk);
    rst = 1'b0;

    // Lab function, HOLD=10
    sweep(0, spec_table(), 1'b0);
    check("spec truth", 32'(truth0), 32'h0000_00D5);
    check("spec ones", 32'(ones0), 5);

    // Constant functions
    sweep(0, 8'h00, 1'b0);
    check("const0 truth", 32'(truth0), 0);
    sweep(0, 8'hFF, 1'b0);
    check("const1 ones", 32'(ones0), 8);

    // HOLD=1
    sweep(1, spec_table(), 1'b0);
    check("hold1 truth", 32'(truth1), 32'h0000_00D5);

    // start noise during DRIVE/DONE, then a clean back-to-back sweep
    rt = 8'($urandom);
    sweep(0, rt, 1'b1);
    rt = 8'($urandom);
    sweep(0, rt, 1'b0);

    // Asynchronous reset mid-sweep at x_out == 5
    set_tbl(0, spec_table());
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (53) @(negedge clk);
    check("pre-rst x0", 32'(x0), 5);
    #2 rst = 1'b1;
    #1;
    check("mid-rst x0", 32'(x0), 0);
    check("mid-rst busy0", 32'(busy0), 0);
    check("mid-rst done0", 32'(done0), 0);
    check("mid-rst truth0", 32'(truth0), 0);
    check("mid-rst ones0", 32'(ones0), 0);
    check("mid-rst truth1", 32'(truth1), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post-rst idle busy0", 32'(busy0), 0);
      check("post-rst idle x0", 32'(x0), 0);
    end
    sweep(0, spec_table(), 1'b0);

    // Idle hold after a sweep
    repeat (50) begin
      @(negedge clk);
      check("idle truth0", 32'(truth0), 32'h0000_00D5);
      check("idle ones0", 32'(ones0), 5);
      check("idle x0", 32'(x0), 0);
      check("idle busy0", 32'(busy0), 0);
    end

    // Random tables with start noise
    for (int i = 0; i < 8; i++) begin
      rt = 8'($urandom);
      sweep(1, rt, 1'b1);
    end
    for (int i = 0; i < 2; i++) begin
      rt = 8'($urandom);
      sweep(0, rt, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
